pixel_plot_writer: RTL and testbench

PIXEL_PLOT_WRITER -- requirements
Module: pixel_plot_writer

---
 rtl/pixel_plot_writer.sv | 102 ++++++++++
 tb/tb_pixel_plot_writer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plot_writer.sv
// pixel_plot_writer: queues line-drawer pixels in a small FIFO and writes them, or a whole-screen
// fill, to the frame buffer through one held output register (addr/colour/we stable until granted).
module pixel_plot_writer #(
   parameter int H_RES = 160,
   parameter int V_RES = 120,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic [2:0]  colour,
   input  logic        plot,
   output logic        ready,
   input  logic        clear,
   input  logic [2:0]  clear_colour,
   output logic [14:0] vga_addr,
   output logic [2:0]  vga_colour,
   output logic        vga_we,
   input  logic        vga_grant,
   output logic        busy,
   output logic [7:0]  clip_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [14:0] LAST = 15'(H_RES * V_RES - 1);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t r_state, w_next;
   logic [17:0] r_mem [DEPTH];
   logic [AW:0] r_wp, r_rp;
   logic        r_pend;
   logic [2:0]  r_clr_col;
   logic [14:0] r_addr;
   logic [2:0]  r_col;
   logic        r_we;
   logic [7:0]  r_clip;
   logic [14:0] w_addr;
   logic        w_empty, w_full, w_in, w_acc, w_push, w_take, w_free, w_pop, w_go, w_done;
   // y*H_RES+x never exceeds 15 bits for any 8-bit x / 7-bit y, so nothing is lost here
   assign w_addr  = 15'(y) * 15'(H_RES) + 15'(x);
   assign w_in    = (32'(x) < H_RES) && (32'(y) < V_RES);
   assign w_empty = r_wp == r_rp;
   assign w_full  = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
   assign ready   = ~reset & ~w_full & (r_state == IDLE) & ~r_pend;
   assign w_acc   = plot & ready;
   assign w_push  = w_acc & w_in;
   assign w_take  = r_we & vga_grant;
   assign w_free  = ~r_we | w_take;
   assign w_pop   = (r_state == IDLE) & ~w_empty & w_free;
   assign w_go    = (r_state == IDLE) & r_pend & w_empty & w_free;
   assign w_done  = (r_state == CLEAR) & w_take & (r_addr == LAST);
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   always_comb begin
      w_next = r_state;
      w_next = w_go ? CLEAR : w_done ? IDLE : r_state;
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp[AW-1:0]] <= {w_addr, colour};
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + (AW+1)'(1);
         if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
      end
   // a clear is only latched when idle and none is already pending; later requests are dropped
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_pend    <= 1'b0;
         r_clr_col <= 3'd0;
         r_clip    <= 8'd0;
      end else begin
         if (clear & (r_state == IDLE) & ~r_pend) begin
            r_pend    <= 1'b1;
            r_clr_col <= clear_colour;
         end else if (w_go) r_pend <= 1'b0;
         if (w_acc & ~w_in & (r_clip != 8'hFF)) r_clip <= r_clip + 8'd1;
      end
   // during CLEAR the output address doubles as the fill counter
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_we   <= 1'b0;
         r_addr <= 15'd0;
         r_col  <= 3'd0;
      end else if (w_pop) begin
         {r_addr, r_col} <= r_mem[r_rp[AW-1:0]];
         r_we            <= 1'b1;
      end else if (w_go) begin
         r_we   <= 1'b1;
         r_addr <= 15'd0;
         r_col  <= r_clr_col;
      end else if (w_done) r_we <= 1'b0;
      else if ((r_state == CLEAR) & w_take) r_addr <= r_addr + 15'd1;
      else if (w_take) r_we <= 1'b0;
   assign vga_addr   = r_addr;
   assign vga_colour = r_col;
   assign vga_we     = r_we;
   assign clip_count = r_clip;
   assign busy       = ~w_empty | r_we | r_pend | (r_state == CLEAR);
endmodule

// File: tb/tb_pixel_plot_writer.sv
// tb_pixel_plot_writer: vector table, hand-written corner sequences and a randomized run checked
// against a queue model of the expected frame-buffer writes.
module tb_pixel_plot_writer;
   localparam int H = 160;
   localparam int V = 120;
   logic        clk = 1'b0, reset = 1'b1, plot = 1'b0, clear = 1'b0, vga_grant = 1'b0;
   logic [7:0]  x = 8'd0;
   logic [6:0]  y = 7'd0;
   logic [2:0]  colour = 3'd0, clear_colour = 3'd0;
   logic        ready, vga_we, busy;
   logic [14:0] vga_addr;
   logic [2:0]  vga_colour;
   logic [7:0]  clip_count;
   pixel_plot_writer dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot), .ready(ready),
      .clear(clear), .clear_colour(clear_colour), .vga_addr(vga_addr), .vga_colour(vga_colour),
      .vga_we(vga_we), .vga_grant(vga_grant), .busy(busy), .clip_count(clip_count)
   );
   always #5 clk = ~clk;
   typedef struct packed {
      logic [7:0]  x;
      logic [6:0]  y;
      logic [2:0]  c;
      logic        ok;
      logic [14:0] addr;
   } vec_t;
   vec_t        vec [9];
   int          checks = 0, failures = 0, clip_exp = 0;
   logic [17:0] exp_q [$];
   bit          chk_rdy = 1'b0, acc, took;
   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask
   // one clock: called at a negedge with inputs already driven, returns at the next negedge
   task automatic cyc();
      logic [17:0] e;
      #1;
      acc  = plot && ready;
      took = vga_we && vga_grant;
      if (chk_rdy) begin
         chk("ready_vs_occupancy", int'(ready), int'(exp_q.size() < 5));
         chk("busy_vs_pending", int'(busy), int'(exp_q.size() != 0));
         chk("clip_count", int'(clip_count), clip_exp);
      end
      if (took) begin
         if (exp_q.size() == 0) chk("unexpected_write", int'(vga_addr), -1);
         else begin
            e = exp_q.pop_front();
            chk("write_addr", int'(vga_addr), int'(e[17:3]));
            chk("write_colour", int'(vga_colour), int'(e[2:0]));
         end
      end
      if (acc) begin
         if (int'(x) < H && int'(y) < V) exp_q.push_back({15'(int'(y) * H + int'(x)), colour});
         else if (clip_exp < 255) clip_exp++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      plot = 1'b0;
      clear = 1'b0;
      vga_grant = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      clip_exp = 0;
   endtask
   // watches fill writes; stops once stop_at writes have been taken or the cycle budget expires
   task automatic fill(input int stop_at, input logic [2:0] col, input bit rnd, output int done, output int errs);
      done = 0;
      errs = 0;
      for (int c = 0; c < 60000 && done < stop_at; c++) begin
         vga_grant = rnd ? ($urandom % 4 != 0) : 1'b1;
         clear = (c == 500);
         clear_colour = (c == 500) ? 3'd2 : col;
         #1;
         if (ready) errs++;
         if (vga_we && vga_grant) begin
            if (vga_addr != 15'(done) || vga_colour != col) errs++;
            done++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      clear = 1'b0;
   endtask
   initial begin
      int n, run, done, errs, wr;
      vec[0] = {8'd5,   7'd2,   3'd3, 1'b1, 15'd325};
      vec[1] = {8'd159, 7'd119, 3'd7, 1'b1, 15'd19199};
      vec[2] = {8'd160, 7'd0,   3'd1, 1'b0, 15'd0};
      vec[3] = {8'd0,   7'd120, 3'd2, 1'b0, 15'd0};
      vec[4] = {8'd0,   7'd0,   3'd5, 1'b1, 15'd0};
      vec[5] = {8'd159, 7'd0,   3'd4, 1'b1, 15'd159};
      vec[6] = {8'd0,   7'd119, 3'd6, 1'b1, 15'd19040};
      vec[7] = {8'd255, 7'd127, 3'd1, 1'b0, 15'd0};
      vec[8] = {8'd80,  7'd60,  3'd2, 1'b1, 15'd9680};
      @(negedge clk);
      chk("in_reset_ready", int'(ready), 0);
      chk("in_reset_we", int'(vga_we), 0);
      chk("in_reset_busy", int'(busy), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_ready", int'(ready), 1);
      chk("idle_we", int'(vga_we), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_clip", int'(clip_count), 0);
      for (int i = 0; i < 9; i++) begin
         x = vec[i].x;
         y = vec[i].y;
         colour = vec[i].c;
         plot = 1'b1;
         vga_grant = 1'b1;
         @(posedge clk);
         #1 plot = 1'b0;
         @(negedge clk);
         chk("vec_we_edge_k", int'(vga_we), 0);
         @(negedge clk);
         chk("vec_we_edge_k1", int'(vga_we), int'(vec[i].ok));
         if (vec[i].ok) begin
            chk("vec_addr", int'(vga_addr), int'(vec[i].addr));
            chk("vec_colour", int'(vga_colour), int'(vec[i].c));
         end
         @(negedge clk);
         chk("vec_we_edge_k2", int'(vga_we), 0);
         if (!vec[i].ok) clip_exp++;
         chk("vec_clip", int'(clip_count), clip_exp);
      end
      chk("vec_clip_total", int'(clip_count), 3);
      chk_rdy = 1'b1;
      vga_grant = 1'b0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         x = 8'(10 + n); y = 7'd1; colour = 3'(n); plot = (n < 7);
         cyc();
         if (acc) n++;
      end
      chk("stall_accepted", n, 5);
      chk("stall_ready", int'(ready), 0);
      vga_grant = 1'b1;
      run = 0;
      for (int c = 0; c < 5; c++) begin
         x = 8'(10 + n); y = 7'd1; colour = 3'(n); plot = (n < 7);
         cyc();
         if (took) run++;
         if (acc) n++;
      end
      chk("stall_burst", run, 5);
      for (int c = 0; c < 20 && (exp_q.size() != 0 || n < 7); c++) begin
         x = 8'(10 + n); y = 7'd1; colour = 3'(n); plot = (n < 7);
         cyc();
         if (acc) n++;
      end
      chk("stall_all_accepted", n, 7);
      chk("stall_drained", exp_q.size(), 0);
      for (int c = 0; c < 800; c++) begin
         x = 8'($urandom_range(0, 175));
         y = 7'($urandom_range(0, 127));
         colour = 3'($urandom);
         plot = ($urandom % 3) != 0;
         vga_grant = ($urandom % 2) != 0;
         cyc();
      end
      plot = 1'b0;
      vga_grant = 1'b1;
      for (int c = 0; c < 10; c++) cyc();
      chk("rand_drained", exp_q.size(), 0);
      x = 8'd200;
      plot = 1'b1;
      for (int c = 0; c < 300; c++) cyc();
      plot = 1'b0;
      cyc();
      chk("clip_saturate", int'(clip_count), 255);
      chk_rdy = 1'b0;
      do_reset();
      #1 chk("reset_clip", int'(clip_count), 0);
      chk("reset_ready", int'(ready), 1);
      @(negedge clk);
      vga_grant = 1'b0;
      x = 8'd10; y = 7'd3; colour = 3'd1; plot = 1'b1;
      cyc();
      x = 8'd20; y = 7'd4; colour = 3'd2; clear = 1'b1; clear_colour = 3'd6;
      cyc();
      chk("plot_with_clear_accepted", int'(acc), 1);
      plot = 1'b0; clear = 1'b0; clear_colour = 3'd1;
      cyc();
      chk("clear_pending_busy", int'(busy), 1);
      chk("clear_pending_ready", int'(ready), 0);
      vga_grant = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) cyc();
      chk("pixels_before_fill", exp_q.size(), 0);
      fill(19200, 3'd6, 1'b1, done, errs);
      chk("fill_count", done, 19200);
      chk("fill_errors", errs, 0);
      #1;
      chk("fill_end_busy", int'(busy), 0);
      chk("fill_end_we", int'(vga_we), 0);
      chk("fill_end_ready", int'(ready), 1);
      wr = 0;
      vga_grant = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1 if (vga_we) wr++;
      end
      chk("no_second_fill", wr, 0);
      @(negedge clk);
      do_reset();
      vga_grant = 1'b1;
      clear = 1'b1;
      clear_colour = 3'd5;
      @(negedge clk);
      clear = 1'b0;
      fill(100, 3'd5, 1'b0, done, errs);
      chk("fill100_errors", errs, 0);
      chk("fill100_addr", int'(vga_addr), 100);
      chk("fill100_we", int'(vga_we), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_we", int'(vga_we), 0);
      chk("async_reset_addr", int'(vga_addr), 0);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_ready", int'(ready), 0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("after_reset_ready", int'(ready), 1);
      wr = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         #1 if (vga_we || busy) wr++;
      end
      chk("after_reset_no_writes", wr, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
